// File: rtl/datapath_pipe.sv
// Three-stage (RD / EX / WB) pipelined KGP-RISC datapath: register bank, ALU, handshaked data-memory port.
// Optional macro DP_FORWARD_EN: forward operands from EX/WB instead of interlocking until the producer commits.

module datapath_pipe #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int IMM_W = 21,
    parameter int SH_W  = 5,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    regAddr_1,
    input  logic [AW-1:0]    regAddr_2,
    input  logic             regWriteEnable,
    input  logic             regWrite_select,
    input  logic             reg_to_pc,
    input  logic [XLEN-1:0]  npc,
    input  logic             reg_data,
    input  logic             ALU_src,
    input  logic             const_src,
    input  logic [IMM_W-1:0] immediate_const,
    input  logic [SH_W-1:0]  shift_amount,
    input  logic [3:0]       alu_control,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             out_valid,
    output logic [XLEN-1:0]  alu_result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             sign_flag,
    output logic             overflow_flag
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_PASSB
    } alu_op_e;

    localparam logic [AW-1:0] LINK_REG = AW'(NREG - 1);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    logic            ex_valid_q, ex_valid_d, ex_mem_rd_q, ex_mem_rd_d, ex_mem_wr_q, ex_mem_wr_d;
    logic            ex_we_q, ex_we_d, ex_reg_data_q, ex_reg_data_d, ex_link_q, ex_link_d;
    logic [XLEN-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_rs2_q, ex_rs2_d, ex_npc_q, ex_npc_d;
    logic [3:0]      ex_op_q, ex_op_d;
    logic [AW-1:0]   ex_dest_q, ex_dest_d;

    logic            wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic [AW-1:0]   wb_dest_q, wb_dest_d;
    logic [XLEN-1:0] wb_wdata_q, wb_wdata_d;

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic            zero_q, zero_d, carry_q, carry_d, sign_q, sign_d, ovf_q, ovf_d;

    logic [AW-1:0]   rd_addr1, rd_dest;
    logic            use_b, accept, hazard_stall;
    logic            ex_is_mem, ex_done, ex_busy, ex_wr, wb_wr;
    logic [XLEN-1:0] rs1_val, rs2_val, const_val, ex_wdata;
    logic [XLEN-1:0] alu_res;
    logic            alu_carry, alu_ovf;
    logic [XLEN:0]   sum_add, sum_sub;
    logic [SH_W-1:0] sh;

    assign rd_addr1  = reg_to_pc ? LINK_REG : regAddr_1;
    assign rd_dest   = reg_to_pc ? LINK_REG : (regWrite_select ? regAddr_2 : regAddr_1);
    assign use_b     = !ALU_src || MemWrite;
    assign ex_is_mem = ex_mem_rd_q || ex_mem_wr_q;
    assign ex_done   = ex_valid_q && (!ex_is_mem || mem_ack);
    assign ex_busy   = ex_valid_q && ex_is_mem;
    assign ex_wr     = ex_valid_q && ex_we_q;
    assign wb_wr     = wb_valid_q && wb_we_q;
    assign ex_wdata  = ex_link_q ? ex_npc_q : (ex_reg_data_q ? mem_rdata : alu_res);
    assign const_val = const_src ? XLEN'(shift_amount) : XLEN'($signed(immediate_const));

`ifdef DP_FORWARD_EN
    logic [XLEN-1:0] ex_fwd;
    logic            ex_load;
    assign ex_fwd  = ex_link_q ? ex_npc_q : alu_res;
    assign ex_load = ex_reg_data_q && !ex_link_q;
    assign hazard_stall = ex_wr && ex_load &&
                          (ex_dest_q == rd_addr1 || (use_b && ex_dest_q == regAddr_2));
`else
    assign hazard_stall =
        (ex_wr && (ex_dest_q == rd_addr1 || (use_b && ex_dest_q == regAddr_2))) ||
        (wb_wr && (wb_dest_q == rd_addr1 || (use_b && wb_dest_q == regAddr_2)));
`endif

    assign in_ready = !rst && !ex_busy && !hazard_stall;
    assign accept   = in_valid && in_ready;

    // Register read; a same-cycle WB write is bypassed so RD sees the new value.
    always_comb begin
        rs1_val = rf_q[rd_addr1];
        rs2_val = rf_q[regAddr_2];
        if (wb_wr && wb_dest_q == rd_addr1)  rs1_val = wb_wdata_q;
        if (wb_wr && wb_dest_q == regAddr_2) rs2_val = wb_wdata_q;
`ifdef DP_FORWARD_EN
        if (ex_wr && !ex_load && ex_dest_q == rd_addr1)  rs1_val = ex_fwd;
        if (ex_wr && !ex_load && ex_dest_q == regAddr_2) rs2_val = ex_fwd;
`endif
    end

    always_comb begin
        sum_add   = {1'b0, ex_a_q} + {1'b0, ex_b_q};
        sum_sub   = {1'b0, ex_a_q} + {1'b0, ~ex_b_q} + {{XLEN{1'b0}}, 1'b1};
        sh        = ex_b_q[SH_W-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (ex_op_q)
            OP_ADD: begin
                alu_res   = sum_add[XLEN-1:0];
                alu_carry = sum_add[XLEN];
                alu_ovf   = (ex_a_q[XLEN-1] == ex_b_q[XLEN-1]) && (alu_res[XLEN-1] != ex_a_q[XLEN-1]);
            end
            OP_SUB: begin
                alu_res   = sum_sub[XLEN-1:0];
                alu_carry = sum_sub[XLEN];
                alu_ovf   = (ex_a_q[XLEN-1] != ex_b_q[XLEN-1]) && (alu_res[XLEN-1] != ex_a_q[XLEN-1]);
            end
            OP_AND:   alu_res = ex_a_q & ex_b_q;
            OP_OR:    alu_res = ex_a_q | ex_b_q;
            OP_XOR:   alu_res = ex_a_q ^ ex_b_q;
            OP_SLL:   alu_res = ex_a_q << sh;
            OP_SRL:   alu_res = ex_a_q >> sh;
            OP_SRA:   alu_res = XLEN'($signed(ex_a_q) >>> sh);
            OP_PASSB: alu_res = ex_b_q;
            default:  alu_res = '0;
        endcase
    end

    assign mem_req   = ex_busy;
    assign mem_we    = ex_busy && ex_mem_wr_q;
    assign mem_addr  = alu_res;
    assign mem_wdata = ex_rs2_q;

    // RD/EX register holds during a memory stall; accept only happens when EX is free or retiring.
    always_comb begin
        ex_valid_d    = ex_valid_q && !ex_done;
        ex_a_d        = ex_a_q;
        ex_b_d        = ex_b_q;
        ex_rs2_d      = ex_rs2_q;
        ex_op_d       = ex_op_q;
        ex_mem_rd_d   = ex_mem_rd_q;
        ex_mem_wr_d   = ex_mem_wr_q;
        ex_we_d       = ex_we_q;
        ex_dest_d     = ex_dest_q;
        ex_reg_data_d = ex_reg_data_q;
        ex_link_d     = ex_link_q;
        ex_npc_d      = ex_npc_q;
        if (accept) begin
            ex_valid_d    = 1'b1;
            ex_a_d        = rs1_val;
            ex_b_d        = ALU_src ? const_val : rs2_val;
            ex_rs2_d      = rs2_val;
            ex_op_d       = alu_control;
            ex_mem_wr_d   = MemWrite;
            ex_mem_rd_d   = MemRead && !MemWrite;
            ex_we_d       = regWriteEnable;
            ex_dest_d     = rd_dest;
            ex_reg_data_d = reg_data;
            ex_link_d     = reg_to_pc;
            ex_npc_d      = npc;
        end
    end

    always_comb begin
        wb_valid_d   = ex_done;
        wb_we_d      = ex_we_q;
        wb_dest_d    = ex_dest_q;
        wb_wdata_d   = ex_wdata;
        alu_result_d = ex_done ? alu_res : alu_result_q;
        zero_d       = ex_done ? (alu_res == '0) : zero_q;
        sign_d       = ex_done ? alu_res[XLEN-1] : sign_q;
        carry_d      = ex_done ? alu_carry : carry_q;
        ovf_d        = ex_done ? alu_ovf : ovf_q;
        rf_d         = rf_q;
        if (wb_wr) rf_d[wb_dest_q] = wb_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            ex_valid_q <= 1'b0; ex_a_q <= '0; ex_b_q <= '0; ex_rs2_q <= '0; ex_op_q <= '0;
            ex_mem_rd_q <= 1'b0; ex_mem_wr_q <= 1'b0; ex_we_q <= 1'b0; ex_dest_q <= '0;
            ex_reg_data_q <= 1'b0; ex_link_q <= 1'b0; ex_npc_q <= '0;
            wb_valid_q <= 1'b0; wb_we_q <= 1'b0; wb_dest_q <= '0; wb_wdata_q <= '0;
            alu_result_q <= '0; zero_q <= 1'b0; carry_q <= 1'b0; sign_q <= 1'b0; ovf_q <= 1'b0;
        end else begin
            rf_q <= rf_d;
            ex_valid_q <= ex_valid_d; ex_a_q <= ex_a_d; ex_b_q <= ex_b_d; ex_rs2_q <= ex_rs2_d;
            ex_op_q <= ex_op_d; ex_mem_rd_q <= ex_mem_rd_d; ex_mem_wr_q <= ex_mem_wr_d;
            ex_we_q <= ex_we_d; ex_dest_q <= ex_dest_d; ex_reg_data_q <= ex_reg_data_d;
            ex_link_q <= ex_link_d; ex_npc_q <= ex_npc_d;
            wb_valid_q <= wb_valid_d; wb_we_q <= wb_we_d; wb_dest_q <= wb_dest_d; wb_wdata_q <= wb_wdata_d;
            alu_result_q <= alu_result_d; zero_q <= zero_d; carry_q <= carry_d;
            sign_q <= sign_d; ovf_q <= ovf_d;
        end
    end

    assign out_valid     = wb_valid_q;
    assign alu_result    = alu_result_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign sign_flag     = sign_q;
    assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed self-checking bench for datapath_pipe (default 32x32 build plus a 16-bit / 16-register instance).
// Works with or without DP_FORWARD_EN; only the expected interlock length differs.

module tb_datapath_pipe;

`ifdef DP_FORWARD_EN
    localparam int B2B_STALLS = 0;
`else
    localparam int B2B_STALLS = 2;
`endif

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_OR = 4'd3, OP_SRL = 4'd6, OP_PASSB = 4'd8;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [4:0]  regAddr_1, regAddr_2;
    logic        regWriteEnable, regWrite_select, reg_to_pc, reg_data, ALU_src, const_src;
    logic [31:0] npc;
    logic [20:0] immediate_const;
    logic [4:0]  shift_amount;
    logic [3:0]  alu_control;
    logic        MemRead, MemWrite;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        out_valid, zero_flag, carry_flag, sign_flag, overflow_flag;
    logic [31:0] alu_result;

    logic        b_valid, b_ready, b_link, b_mem_req, b_mem_we, b_out_valid, b_z, b_c, b_s, b_v;
    logic [3:0]  b_a1, b_op;
    logic [15:0] b_npc, b_mem_addr, b_mem_wdata, b_alu_result;
    logic        b_we;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        s;
        logic        v;
    } result_t;
    result_t res_q[$];

    datapath_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .regAddr_1(regAddr_1), .regAddr_2(regAddr_2), .regWriteEnable(regWriteEnable),
        .regWrite_select(regWrite_select), .reg_to_pc(reg_to_pc), .npc(npc), .reg_data(reg_data),
        .ALU_src(ALU_src), .const_src(const_src), .immediate_const(immediate_const),
        .shift_amount(shift_amount), .alu_control(alu_control), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid), .alu_result(alu_result),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .sign_flag(sign_flag), .overflow_flag(overflow_flag)
    );

    datapath_pipe #(.XLEN(16), .NREG(16), .IMM_W(8), .SH_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .regAddr_1(b_a1), .regAddr_2(4'd0), .regWriteEnable(b_we),
        .regWrite_select(1'b0), .reg_to_pc(b_link), .npc(b_npc), .reg_data(1'b0),
        .ALU_src(1'b1), .const_src(1'b0), .immediate_const(8'd0),
        .shift_amount(4'd0), .alu_control(b_op), .MemRead(1'b0), .MemWrite(1'b0),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ack(1'b0), .mem_rdata(16'd0), .out_valid(b_out_valid), .alu_result(b_alu_result),
        .zero_flag(b_z), .carry_flag(b_c), .sign_flag(b_s), .overflow_flag(b_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (out_valid) res_q.push_back({alu_result, zero_flag, carry_flag, sign_flag, overflow_flag});

    initial begin
        #400000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic setInstr(input logic [3:0] op, input logic [4:0] a1, input logic [4:0] a2,
                            input logic src, input logic csrc, input logic [20:0] imm,
                            input logic we, input logic sel);
        alu_control = op; regAddr_1 = a1; regAddr_2 = a2; ALU_src = src; const_src = csrc;
        immediate_const = imm; shift_amount = imm[4:0]; regWriteEnable = we; regWrite_select = sel;
        MemRead = 1'b0; MemWrite = 1'b0; reg_data = 1'b0; reg_to_pc = 1'b0; npc = '0;
    endtask

    // Present the instruction and count the cycles it waits for in_ready; returns just after the accept edge.
    task automatic applyStimulus(input string tag, output int stalls);
        in_valid = 1'b1;
        stalls = 0;
        #1;
        while (!in_ready && stalls < 40) begin
            @(negedge clk); #1;
            stalls++;
        end
        checkOutput({tag, "_accept"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic getResult(input string tag, output result_t r);
        for (int i = 0; i < 30 && res_q.size() == 0; i++) begin
            @(negedge clk); #1;
        end
        checkOutput({tag, "_out_valid"}, 32'(res_q.size() != 0), 32'd1);
        if (res_q.size() != 0) r = res_q.pop_front();
        else r = '0;
    endtask

    initial begin
        int st;
        result_t r;

        rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        b_valid = 1'b0; b_a1 = '0; b_op = '0; b_we = 1'b0; b_link = 1'b0; b_npc = '0;
        setInstr(OP_ADD, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_alu_result", alu_result, 0);
        checkOutput("rst_flags", {28'd0, zero_flag, carry_flag, sign_flag, overflow_flag}, 0);
        checkOutput("rst_mem", {30'd0, mem_req, mem_we}, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        setInstr(OP_PASSB, 0, 5, 0, 0, 0, 0, 0);
        applyStimulus("rd_r5", st);
        getResult("rd_r5", r);
        checkOutput("rd_r5_result", r.res, 0);
        checkOutput("rd_r5_zero", 32'(r.z), 1);

        setInstr(OP_ADD, 1, 0, 1, 0, 21'd5, 1, 0);
        applyStimulus("b2b_add", st);
        setInstr(OP_SUB, 1, 1, 0, 0, 0, 1, 0);
        applyStimulus("b2b_sub", st);
        checkOutput("b2b_stalls", st, B2B_STALLS);
        getResult("b2b_add", r);
        checkOutput("b2b_add_result", r.res, 5);
        getResult("b2b_sub", r);
        checkOutput("b2b_sub_result", r.res, 0);
        checkOutput("b2b_sub_zero", 32'(r.z), 1);
        checkOutput("b2b_sub_carry", 32'(r.c), 1);

        setInstr(OP_ADD, 1, 7, 1, 0, 21'd7, 1, 1);
        applyStimulus("chain_r7", st);
        setInstr(OP_ADD, 7, 8, 1, 0, 21'd1, 1, 1);
        applyStimulus("chain_r8", st);
        setInstr(OP_OR, 7, 8, 0, 0, 0, 0, 0);
        applyStimulus("chain_or", st);
        getResult("chain_r7", r);
        checkOutput("chain_r7_result", r.res, 7);
        getResult("chain_r8", r);
        checkOutput("chain_r8_result", r.res, 8);
        getResult("chain_or", r);
        checkOutput("chain_or_result", r.res, 15);

        setInstr(OP_ADD, 0, 3, 1, 0, 21'h1FFFFF, 1, 1);
        applyStimulus("neg1", st);
        getResult("neg1", r);
        checkOutput("neg1_result", r.res, 32'hFFFFFFFF);
        checkOutput("neg1_flags", {28'd0, r.z, r.c, r.s, r.v}, 32'b0010);

        setInstr(OP_SRL, 3, 0, 1, 1, 21'd1, 1, 0);
        applyStimulus("srl", st);
        getResult("srl", r);
        checkOutput("srl_result", r.res, 32'h7FFFFFFF);

        setInstr(OP_ADD, 3, 0, 1, 0, 21'd1, 0, 0);
        applyStimulus("add_ovf", st);
        getResult("add_ovf", r);
        checkOutput("add_ovf_result", r.res, 32'h80000000);
        checkOutput("add_ovf_flags", {28'd0, r.z, r.c, r.s, r.v}, 32'b0011);

        setInstr(OP_SUB, 0, 0, 1, 0, 21'd1, 0, 0);
        applyStimulus("sub_neg", st);
        getResult("sub_neg", r);
        checkOutput("sub_neg_result", r.res, 32'hFFFFFFFF);
        checkOutput("sub_neg_flags", {28'd0, r.z, r.c, r.s, r.v}, 32'b0010);

        setInstr(OP_SUB, 7, 0, 1, 0, 21'd3, 0, 0);
        applyStimulus("sub_pos", st);
        getResult("sub_pos", r);
        checkOutput("sub_pos_result", r.res, 4);
        checkOutput("sub_pos_carry", 32'(r.c), 1);

        setInstr(OP_ADD, 7, 10, 1, 0, 21'h10, 1, 1);
        MemRead = 1'b1; reg_data = 1'b1;
        applyStimulus("load", st);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("load_mem_req", 32'(mem_req), 1);
            checkOutput("load_mem_we", 32'(mem_we), 0);
            checkOutput("load_mem_addr", mem_addr, 32'h17);
            checkOutput("load_in_ready", 32'(in_ready), 0);
            if (c == 2) begin
                mem_ack = 1'b1; mem_rdata = 32'h1234;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0; mem_rdata = '0;
        getResult("load", r);
        checkOutput("load_result", r.res, 32'h17);
        setInstr(OP_ADD, 10, 11, 1, 0, 21'd1, 0, 1);
        applyStimulus("use_load", st);
        getResult("use_load", r);
        checkOutput("use_load_result", r.res, 32'h1235);

        setInstr(OP_ADD, 7, 10, 1, 0, 0, 0, 0);
        MemWrite = 1'b1;
        applyStimulus("store", st);
        #1;
        checkOutput("store_mem", {30'd0, mem_req, mem_we}, 32'b11);
        checkOutput("store_mem_addr", mem_addr, 7);
        checkOutput("store_mem_wdata", mem_wdata, 32'h1234);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        getResult("store", r);
        checkOutput("store_result", r.res, 7);

        setInstr(OP_PASSB, 0, 0, 1, 0, 0, 1, 0);
        reg_to_pc = 1'b1; npc = 32'h40;
        applyStimulus("link", st);
        setInstr(OP_OR, 31, 0, 1, 0, 0, 0, 0);
        applyStimulus("link_read", st);
        getResult("link", r);
        checkOutput("link_result", r.res, 0);
        getResult("link_read", r);
        checkOutput("link_read_result", r.res, 32'h40);

        setInstr(OP_ADD, 7, 12, 1, 0, 0, 1, 1);
        MemRead = 1'b1; reg_data = 1'b1;
        applyStimulus("rst_load", st);
        #1;
        checkOutput("rst_load_req_before", 32'(mem_req), 1);
        rst = 1'b1;
        @(negedge clk); #1;
        checkOutput("rst_load_req_after", 32'(mem_req), 0);
        checkOutput("rst_load_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h5555;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_load_no_result", res_q.size(), 0);
        setInstr(OP_PASSB, 0, 12, 0, 0, 0, 0, 0);
        applyStimulus("rst_r12", st);
        getResult("rst_r12", r);
        checkOutput("rst_r12_result", r.res, 0);
        setInstr(OP_PASSB, 0, 10, 0, 0, 0, 0, 0);
        applyStimulus("rst_r10", st);
        getResult("rst_r10", r);
        checkOutput("rst_r10_result", r.res, 0);

        // Narrow build: link write lands in r15 and reads back through port 1.
        b_op = OP_PASSB[3:0]; b_a1 = 4'd0; b_we = 1'b1; b_link = 1'b1; b_npc = 16'h0040; b_valid = 1'b1;
        #1;
        checkOutput("b_link_ready", 32'(b_ready), 1);
        @(negedge clk);
        b_valid = 1'b0; b_link = 1'b0; b_we = 1'b0;
        repeat (4) @(negedge clk);
        b_op = OP_OR; b_a1 = 4'd15; b_valid = 1'b1;
        for (int i = 0; i < 10 && !b_ready; i++) begin
            @(negedge clk); #1;
        end
        checkOutput("b_read_ready", 32'(b_ready), 1);
        @(negedge clk);
        b_valid = 1'b0;
        for (int i = 0; i < 10 && !b_out_valid; i++) begin
            @(negedge clk); #1;
        end
        checkOutput("b_read_valid", 32'(b_out_valid), 1);
        checkOutput("b_read_result", 32'(b_alu_result), 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
